// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand select, EX/MEM and MEM/WB forwarding and load-use bubble.
// EX_FORWARD_EN builds the forwarding muxes, hold-refresh and load-use stall; without it operands come straight from the register.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_OP_WIDTH   = 10,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [DATA_WIDTH-1:0]     id_pc,
    input  logic [DATA_WIDTH-1:0]     id_rs1_data,
    input  logic [DATA_WIDTH-1:0]     id_rs2_data,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                      id_rd_we,
    input  logic                      id_is_load,
    input  logic                      id_src1_pc,
    input  logic                      id_src2_imm,
    input  logic [ALU_OP_WIDTH-1:0]   id_alu_op,
    input  logic                      flush,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [DATA_WIDTH-1:0]     alu_src_1,
    output logic [DATA_WIDTH-1:0]     alu_src_2,
    output logic [ALU_OP_WIDTH-1:0]   operation,
    output logic [DATA_WIDTH-1:0]     ex_rs2_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_rd_we,
    output logic                      ex_is_load,
    input  logic                      mem_fwd_we,
    input  logic                      mem_fwd_is_load,
    input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
    input  logic                      wb_fwd_we,
    input  logic [REG_ADDR_WIDTH-1:0] wb_fwd_rd,
    input  logic [DATA_WIDTH-1:0]     wb_fwd_data
);
    logic                      valid_q;
    logic [DATA_WIDTH-1:0]     pc_q, rs1_q, rs2_q, imm_q;
    logic [REG_ADDR_WIDTH-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
    logic                      rd_we_q, is_load_q, src1_pc_q, src2_imm_q;
    logic [ALU_OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0]     fwd_rs1, fwd_rs2;
    logic                      lu_stall;

`ifdef EX_FORWARD_EN
    logic mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    always_comb begin
        mem_hit1 = mem_fwd_we && mem_fwd_rd == rs1_addr_q && rs1_addr_q != '0;
        mem_hit2 = mem_fwd_we && mem_fwd_rd == rs2_addr_q && rs2_addr_q != '0;
        wb_hit1  = wb_fwd_we && wb_fwd_rd == rs1_addr_q && rs1_addr_q != '0;
        wb_hit2  = wb_fwd_we && wb_fwd_rd == rs2_addr_q && rs2_addr_q != '0;
        fwd_rs1  = mem_hit1 ? mem_fwd_data : wb_hit1 ? wb_fwd_data : rs1_q;
        fwd_rs2  = mem_hit2 ? mem_fwd_data : wb_hit2 ? wb_fwd_data : rs2_q;
        lu_stall = valid_q && mem_fwd_we && mem_fwd_is_load && mem_fwd_rd != '0 &&
                   ((!src1_pc_q && mem_fwd_rd == rs1_addr_q) || mem_fwd_rd == rs2_addr_q);
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{mem_fwd_we, mem_fwd_is_load, mem_fwd_rd, mem_fwd_data,
                          wb_fwd_we, wb_fwd_rd, wb_fwd_data, rs1_addr_q, rs2_addr_q};
    assign fwd_rs1  = rs1_q;
    assign fwd_rs2  = rs2_q;
    assign lu_stall = 1'b0;
`endif

    assign ex_valid    = valid_q && !lu_stall;
    assign operation   = ex_valid ? op_q : '0;
    assign alu_src_1   = src1_pc_q ? pc_q : fwd_rs1;
    assign alu_src_2   = src2_imm_q ? imm_q : fwd_rs2;
    assign ex_rs2_data = fwd_rs2;
    assign ex_rd_addr  = rd_addr_q;
    assign ex_rd_we    = rd_we_q;
    assign ex_is_load  = is_load_q;
    assign id_ready    = !valid_q || (ex_ready && !lu_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            rd_we_q    <= 1'b0;
            is_load_q  <= 1'b0;
            src1_pc_q  <= 1'b0;
            src2_imm_q <= 1'b0;
            op_q       <= '0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (id_valid && id_ready) begin
            valid_q    <= 1'b1;
            pc_q       <= id_pc;
            rs1_q      <= id_rs1_data;
            rs2_q      <= id_rs2_data;
            imm_q      <= id_imm;
            rs1_addr_q <= id_rs1_addr;
            rs2_addr_q <= id_rs2_addr;
            rd_addr_q  <= id_rd_addr;
            rd_we_q    <= id_rd_we;
            is_load_q  <= id_is_load;
            src1_pc_q  <= id_src1_pc;
            src2_imm_q <= id_src2_imm;
            op_q       <= id_alu_op;
        end else if (ex_valid && ex_ready) begin
            valid_q <= 1'b0;
        end else begin
            // refresh held operands so a producer retiring during a stall is kept
            rs1_q <= fwd_rs1;
            rs2_q <= fwd_rs2;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage; expectations adapt to EX_FORWARD_EN.
module tb_id_ex_stage;
`ifdef EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [9:0] ADD = 10'b0000000001, SUB = 10'b0000000010, OR_OP = 10'b0000000100,
                           AND_OP = 10'b0000001000, XOR_OP = 10'b0000010000, SLT = 10'b0000100000;

    logic        clk, rst, id_valid, id_ready, id_rd_we, id_is_load, id_src1_pc, id_src2_imm, flush;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [9:0]  id_alu_op, operation;
    logic        ex_valid, ex_ready, ex_rd_we, ex_is_load;
    logic [31:0] alu_src_1, alu_src_2, ex_rs2_data;
    logic [4:0]  ex_rd_addr;
    logic        mem_fwd_we, mem_fwd_is_load, wb_fwd_we;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_rd_we(id_rd_we), .id_is_load(id_is_load), .id_src1_pc(id_src1_pc),
        .id_src2_imm(id_src2_imm), .id_alu_op(id_alu_op), .flush(flush), .ex_valid(ex_valid),
        .ex_ready(ex_ready), .alu_src_1(alu_src_1), .alu_src_2(alu_src_2), .operation(operation),
        .ex_rs2_data(ex_rs2_data), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we),
        .ex_is_load(ex_is_load), .mem_fwd_we(mem_fwd_we), .mem_fwd_is_load(mem_fwd_is_load),
        .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data), .wb_fwd_we(wb_fwd_we),
        .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data)
    );

    typedef struct {
        string       tag;
        logic [31:0] a1, a2;
        logic [9:0]  op;
    } exp_t;
    exp_t sb[$];
    int   n_vec = 0, n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] a1, input logic [31:0] a2, input logic [9:0] op);
        sb.push_back('{tag, a1, a2, op});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [4:0] r1a, input logic [31:0] r1d,
                         input logic [4:0] r2a, input logic [31:0] r2d, input logic [31:0] imm,
                         input logic [4:0] rd, input logic s1, input logic s2, input logic [9:0] op);
        id_valid = 1'b1; id_pc = pc; id_rs1_addr = r1a; id_rs1_data = r1d; id_rs2_addr = r2a;
        id_rs2_data = r2d; id_imm = imm; id_rd_addr = rd; id_rd_we = 1'b1; id_is_load = 1'b0;
        id_src1_pc = s1; id_src2_imm = s2; id_alu_op = op;
    endtask

    task automatic set_mem(input logic we, input logic ld, input logic [4:0] rd, input logic [31:0] d);
        mem_fwd_we = we; mem_fwd_is_load = ld; mem_fwd_rd = rd; mem_fwd_data = d;
    endtask

    task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        wb_fwd_we = we; wb_fwd_rd = rd; wb_fwd_data = d;
    endtask

    // every EX handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (sb.size() == 0) chk("sb_extra", sb.size(), 1);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.tag, "_src1"}, alu_src_1, e.a1);
                chk({e.tag, "_src2"}, alu_src_2, e.a2);
                chk({e.tag, "_op"}, operation, e.op);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
        id_valid = 1'b0; id_rd_we = 1'b0;
        set_mem(0, 0, 0, 0);
        set_wb(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_op", operation, 0);
        chk("rst_id_ready", id_ready, 1);
        chk("rst_src1", alu_src_1, 0);
        rst = 1'b0;
        tick();
        chk("rel_ex_valid", ex_valid, 0);
        chk("rel_id_ready", id_ready, 1);
        issue(32'h100, 5, 32'h10, 6, 32'h20, 0, 7, 0, 0, ADD);
        tick();
        push("add", 32'h10, 32'h20, ADD);
        chk("add_ex_valid", ex_valid, 1);
        chk("add_rd_addr", ex_rd_addr, 7);
        chk("add_rd_we", ex_rd_we, 1);
        issue(32'h200, 5, 32'h10, 6, 32'h20, 32'hFFFF_FFF0, 8, 1, 1, SUB);
        tick();
        set_mem(1, 0, 5, 32'hAA);
        push("pc_imm", 32'h200, 32'hFFFF_FFF0, SUB);
        issue(32'h204, 5, 32'h10, 6, 32'h20, 0, 7, 0, 0, ADD);
        tick();
        set_mem(1, 0, 5, 32'hAA);
        set_wb(1, 5, 32'hBB);
        push("fwd_mem", FWD ? 32'hAA : 32'h10, 32'h20, ADD);
        issue(32'h208, 5, 32'h10, 6, 32'h20, 0, 7, 0, 0, ADD);
        tick();
        set_mem(1, 0, 0, 32'hAA);
        push("fwd_wb", FWD ? 32'hBB : 32'h10, 32'h20, ADD);
        issue(32'h20C, 0, 32'h0, 6, 32'h20, 0, 7, 0, 0, OR_OP);
        tick();
        set_mem(1, 0, 0, 32'hAA);
        set_wb(1, 0, 32'hBB);
        push("x0", 32'h0, 32'h20, OR_OP);
        issue(32'h210, 5, 32'h10, 6, 32'h20, 0, 7, 0, 0, ADD);
        tick();
        set_mem(1, 1, 6, 32'hDEAD);
        set_wb(0, 0, 0);
        issue(32'h214, 5, 32'h10, 6, 32'h20, 0, 9, 0, 0, AND_OP);
`ifdef EX_FORWARD_EN
        @(negedge clk);
        chk("lu_ex_valid", ex_valid, 0);
        chk("lu_id_ready", id_ready, 0);
        chk("lu_op", operation, 0);
        tick();
        set_mem(0, 0, 0, 0);
        set_wb(1, 6, 32'h55);
        push("lu_wb", 32'h10, 32'h55, ADD);
        tick();
`else
        push("lu_nofwd", 32'h10, 32'h20, ADD);
        @(negedge clk);
        chk("lu_ex_valid", ex_valid, 1);
        chk("lu_id_ready", id_ready, 1);
        tick();
`endif
        id_valid = 1'b0;
        ex_ready = 1'b0;
        set_mem(0, 0, 0, 0);
        set_wb(1, 5, 32'h77);
        @(negedge clk);
        chk("hold1_src1", alu_src_1, FWD ? 32'h77 : 32'h10);
        chk("hold1_ex_valid", ex_valid, 1);
        chk("hold1_id_ready", id_ready, 0);
        tick();
        set_wb(0, 0, 0);
        @(negedge clk);
        chk("hold2_src1", alu_src_1, FWD ? 32'h77 : 32'h10);
        tick();
        ex_ready = 1'b1;
        push("hold3", FWD ? 32'h77 : 32'h10, 32'h20, AND_OP);
        @(negedge clk);
        chk("hold3_src1", alu_src_1, FWD ? 32'h77 : 32'h10);
        tick();
        issue(32'h300, 5, 32'h10, 6, 32'h20, 0, 10, 0, 0, XOR_OP);
        tick();
        ex_ready = 1'b0;
        flush = 1'b1;
        issue(32'h304, 5, 32'h11, 6, 32'h22, 0, 11, 0, 0, SLT);
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        ex_ready = 1'b1;
        @(negedge clk);
        chk("flush_ex_valid", ex_valid, 0);
        chk("flush_op", operation, 0);
        chk("flush_id_ready", id_ready, 1);
        tick();
        issue(32'h400, 5, 32'h10, 6, 32'h20, 0, 12, 0, 0, ADD);
        tick();
        id_valid = 1'b0;
        ex_ready = 1'b0;
        set_mem(1, 1, 6, 32'hDEAD);
        #1;
        chk("pre_rst_id_ready", id_ready, 0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_ex_valid", ex_valid, 0);
        chk("mid_rst_id_ready", id_ready, 1);
        chk("mid_rst_src1", alu_src_1, 0);
        chk("mid_rst_op", operation, 0);
        chk("mid_rst_rd_we", ex_rd_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ex_ready = 1'b1;
        set_mem(0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            issue(32'h500 + 4 * i, 5, 32'h1000 + i, 6, 32'h2000 + 3 * i, 0, 13, 0, 0, 10'(1 << i));
            tick();
            push("stream", 32'h1000 + i, 32'h2000 + 3 * i, 10'(1 << i));
            chk("stream_id_ready", id_ready, 1);
        end
        id_valid = 1'b0;
        tick();
        chk("stream_end_ex_valid", ex_valid, 0);
        repeat (2) tick();
        chk("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the core: it captures one decoded instruction per handshake and drives the ALU operand and one-hot operation inputs for the execute stage. Operand select (PC or rs1, imm or rs2) and EX/MEM and MEM/WB result forwarding happen here. The stage holds the instruction under downstream back-pressure and inserts a one-cycle bubble on a load-use hazard. A one-entry skid-free register sits between decode and the ALU.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width (matches `DATA_WIDTH)
- ALU_OP_WIDTH, 10, one-hot ALU operation width (matches `ALU_OP_WIDTH)
- REG_ADDR_WIDTH, 5, architectural register index width

Ports (single clock `clk`; reset `rst` is asynchronous, active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  decode offers an instruction
- id_ready  out  1  stage accepts this cycle
- id_pc  in  DATA_WIDTH  instruction PC
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_ADDR_WIDTH  register indices
- id_rd_we  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- id_src1_pc  in  1  select PC as ALU source 1
- id_src2_imm  in  1  select imm as ALU source 2
- id_alu_op  in  ALU_OP_WIDTH  one-hot operation
- flush  in  1  kill the held instruction (branch redirect)
- ex_valid  out  1  ALU inputs carry a live instruction
- ex_ready  in  1  downstream consumes the EX result
- alu_src_1, alu_src_2  out  DATA_WIDTH  ALU operands
- operation  out  ALU_OP_WIDTH  ALU one-hot op; all-zero when not ex_valid
- ex_rs2_data  out  DATA_WIDTH  forwarded rs2 (store data)
- ex_rd_addr  out  REG_ADDR_WIDTH,  ex_rd_we  out  1,  ex_is_load  out  1
- mem_fwd_we, mem_fwd_is_load  in  1;  mem_fwd_rd  in  REG_ADDR_WIDTH;  mem_fwd_data  in  DATA_WIDTH  EX/MEM producer
- wb_fwd_we  in  1;  wb_fwd_rd  in  REG_ADDR_WIDTH;  wb_fwd_data  in  DATA_WIDTH  MEM/WB producer

## Operation
- State: valid_q plus registered pc, rs1, rs2, imm, addresses, controls.
- Forwarded value per source: MEM match (we && rd==addr && addr!=0) takes priority over WB match; otherwise the registered value. x0 is never forwarded.
- lu_stall = valid_q && mem_fwd_we && mem_fwd_is_load && mem_fwd_rd!=0 && mem_fwd_rd matches a used source (rs1 when !src1_pc; rs2 always).
- ex_valid = valid_q && !lu_stall; operation = id_alu_op_q gated by ex_valid, so the ALU output is 0 on bubbles.
- alu_src_1 = src1_pc ? pc_q : fwd_rs1; alu_src_2 = src2_imm ? imm_q : fwd_rs2; ex_rs2_data = fwd_rs2.
- id_ready = !valid_q || (ex_ready && !lu_stall).
- Per edge, in priority order: flush -> valid_q=0 (any same-cycle id_valid is dropped); load (id_valid && id_ready) -> capture all fields, valid_q=1; EX consumed with no new instruction -> valid_q=0; hold -> rs1_q/rs2_q are overwritten with their forwarded values, so a WB producer retiring during a stall is not lost.

## Timing
- Reset: valid_q=0, all registers 0; hence ex_valid=0, operation=0, alu_src_*=0, ex_rd_we=0, id_ready=1.
- Latency: 1 cycle from the ID handshake to the ALU inputs; forwarding is combinational in the same cycle.
- Throughput: 1 instruction/cycle when ex_ready=1 and there is no hazard.
- Load-use: exactly one bubble cycle; the next cycle the producer is in WB and is forwarded from there.
- rst asserted mid-stall returns to the reset state immediately.

## Configuration
- EX_FORWARD_EN defined: forwarding muxes, hold-refresh and load-use bubble are built as described.
- Not defined: fwd_rs* = registered values, lu_stall=0 and no hold-refresh. The mem_/wb_ ports remain but are ignored. Hazards are then the decoder's responsibility.

## Test plan
- Reset release, id_valid=0 -> ex_valid=0, operation=0, id_ready=1.
- ADD with rs1=5 (0x10), rs2=6 (0x20) and no producers -> next cycle alu_src_1=0x10, alu_src_2=0x20, operation=ADD one-hot, ex_valid=1.
- Same ADD with mem_fwd rd=5 data 0xAA and wb_fwd rd=5 data 0xBB -> alu_src_1=0xAA; change mem_fwd_rd to 0 -> alu_src_1=0xBB, never a forward to x0.
- mem_fwd_is_load=1, rd=6 matching rs2 -> ex_valid=0 and id_ready=0 for one cycle; next cycle with wb_fwd rd=6 data 0x55 -> alu_src_2=0x55, ex_valid=1.
- ex_ready=0 for 3 cycles while wb_fwd writes rd=5=0x77 in cycle 1 only -> alu_src_1 stays 0x77 through cycle 3.
- flush with id_valid=1 in the same cycle -> next cycle ex_valid=0, incoming instruction dropped; undef EX_FORWARD_EN -> forwarding test shows the register-file value 0x10.
